// File: rtl/lpm_table_scheduler_pkg.sv
// Shared definitions for the LPM table scheduler.
//   - Entry field layout of one 128-bit table word.
//   - Scheduler FSM state enumeration.
//   - Default table address width, oif width, counter width.
//   - sat_inc: saturating increment used by the statistics counters.
package lpm_table_scheduler_pkg;

  localparam int unsigned TBL_ADDR_BITS_DEF = 5;
  localparam int unsigned IP_W              = 32;
  localparam int unsigned OIF_W             = 8;
  localparam int unsigned CNT_W             = 32;
  localparam int unsigned ENTRY_W           = 128;

  // Entry layout: [127:96] prefix, [95:64] mask, [63:32] next hop, [7:0] oif
  localparam int unsigned PREFIX_LSB = 96;
  localparam int unsigned MASK_LSB   = 64;
  localparam int unsigned HOP_LSB    = 32;
  localparam int unsigned OIF_LSB    = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOST_WR = 3'd1,
    HOST_RD = 3'd2,
    SCAN    = 3'd3,
    DRAIN   = 3'd4,
    RESULT  = 3'd5
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/lpm_match_cmp.sv
// Registered match / longest-prefix compare of one table entry against the
// best match seen so far in the current scan.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_clr           clear best-match state (new lookup accepted)
//   i_en            i_entry/i_idx carry a returned table entry this cycle
//   i_entry, i_idx  entry data and its table index
//   i_ip            lookup address
//   o_hit, o_next_hop, o_oif, o_idx   current best match (zero on no match)
module lpm_match_cmp
  import lpm_table_scheduler_pkg::*;
#(
  parameter int unsigned ENTRY_W_P = ENTRY_W,
  parameter int unsigned IDX_W     = TBL_ADDR_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [ENTRY_W_P-1:0] i_entry,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [IP_W-1:0]      i_ip,
  output logic                 o_hit,
  output logic [IP_W-1:0]      o_next_hop,
  output logic [OIF_W-1:0]     o_oif,
  output logic [IDX_W-1:0]     o_idx
);

  logic [IP_W-1:0]  w_prefix;
  logic [IP_W-1:0]  w_mask;
  logic [IP_W-1:0]  w_hop;
  logic [OIF_W-1:0] w_oif;
  logic             w_match;
  logic             w_better;
  logic             w_unused_rsvd;

  logic             r_hit;
  logic [IP_W-1:0]  r_mask;
  logic [IP_W-1:0]  r_hop;
  logic [OIF_W-1:0] r_oif;
  logic [IDX_W-1:0] r_idx;

  assign w_prefix      = i_entry[PREFIX_LSB +: IP_W];
  assign w_mask        = i_entry[MASK_LSB +: IP_W];
  assign w_hop         = i_entry[HOP_LSB +: IP_W];
  assign w_oif         = i_entry[OIF_LSB +: OIF_W];
  assign w_unused_rsvd = ^i_entry[HOP_LSB-1:OIF_LSB+OIF_W];

  // Zero mask marks an invalid entry.
  assign w_match  = i_en && (w_mask != '0) && ((i_ip & w_mask) == (w_prefix & w_mask));
  // Entries arrive in ascending index order, so a strict compare keeps the
  // lower index on equal masks.
  assign w_better = !r_hit || (w_mask > r_mask);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit  <= 1'b0;
      r_mask <= '0;
      r_hop  <= '0;
      r_oif  <= '0;
      r_idx  <= '0;
    end else if (i_clr) begin
      r_hit  <= 1'b0;
      r_mask <= '0;
      r_hop  <= '0;
      r_oif  <= '0;
      r_idx  <= '0;
    end else if (w_match && w_better) begin
      r_hit  <= 1'b1;
      r_mask <= w_mask;
      r_hop  <= w_hop;
      r_oif  <= w_oif;
      r_idx  <= i_idx;
    end
  end

  assign o_hit      = r_hit;
  assign o_next_hop = r_hop;
  assign o_oif      = r_oif;
  assign o_idx      = r_idx;

endmodule

// File: rtl/lpm_table_scheduler.sv
// Longest-prefix-match lookup engine sharing one external table with a host.
// A lookup streams every table entry through lpm_match_cmp and reports the
// best match; host reads/writes are latched and served between lookups.
// Ports:
//   AXI_ACLK, AXI_RESET        clock, asynchronous active-high reset
//   lu_*                       lookup request / result interface
//   host_*                     host table read/write requests and acks
//   tbl_*                      external table read/write port
//   counter_clr, lpm_*_count   saturating hit/miss statistics
module lpm_table_scheduler
  import lpm_table_scheduler_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned TBL_ADDR_BITS      = TBL_ADDR_BITS_DEF
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESET,
  input  logic                            lu_req,
  input  logic [IP_W-1:0]                 lu_ip,
  output logic                            lu_ready,
  output logic                            lu_valid,
  output logic                            lu_hit,
  output logic [IP_W-1:0]                 lu_next_hop,
  output logic [OIF_W-1:0]                lu_oif,
  output logic [TBL_ADDR_BITS-1:0]        lu_index,
  input  logic                            host_rd_req,
  input  logic                            host_wr_req,
  input  logic [TBL_ADDR_BITS-1:0]        host_rd_addr,
  input  logic [TBL_ADDR_BITS-1:0]        host_wr_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] host_wr_data,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] host_rd_data,
  output logic                            host_rd_ack,
  output logic                            host_wr_ack,
  output logic                            tbl_rd_req,
  output logic [TBL_ADDR_BITS-1:0]        tbl_rd_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                            tbl_rd_ack,
  output logic                            tbl_wr_req,
  output logic [TBL_ADDR_BITS-1:0]        tbl_wr_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic                            tbl_wr_ack,
  input  logic                            counter_clr,
  output logic [CNT_W-1:0]                lpm_hit_count,
  output logic [CNT_W-1:0]                lpm_miss_count
);

  localparam int unsigned LP_ENTRY_W = 4 * C_S_AXI_DATA_WIDTH;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic                     r_wr_pend;
  logic                     r_rd_pend;
  logic [TBL_ADDR_BITS-1:0] r_wr_addr;
  logic [TBL_ADDR_BITS-1:0] r_rd_addr;
  logic [LP_ENTRY_W-1:0]    r_wr_data;
  logic                     r_issued;

  logic [TBL_ADDR_BITS-1:0] r_scan_addr;
  logic [TBL_ADDR_BITS-1:0] r_ack_cnt;
  logic [IP_W-1:0]          r_lu_ip;

  logic                     r_lu_valid;
  logic                     r_lu_hit;
  logic [IP_W-1:0]          r_lu_next_hop;
  logic [OIF_W-1:0]         r_lu_oif;
  logic [TBL_ADDR_BITS-1:0] r_lu_index;

  logic [LP_ENTRY_W-1:0]    r_host_rd_data;
  logic                     r_host_rd_ack;
  logic                     r_host_wr_ack;

  logic [CNT_W-1:0]         r_hit_cnt;
  logic [CNT_W-1:0]         r_miss_cnt;

  logic                     w_accept;
  logic                     w_scan_ack;
  logic                     w_best_hit;
  logic [IP_W-1:0]          w_best_hop;
  logic [OIF_W-1:0]         w_best_oif;
  logic [TBL_ADDR_BITS-1:0] w_best_idx;

  // Held low during reset so the port only reads ready once reset is released.
  assign lu_ready   = (r_state == IDLE) && !r_wr_pend && !r_rd_pend && !AXI_RESET;
  assign w_accept   = lu_ready && lu_req;
  assign w_scan_ack = tbl_rd_ack && ((r_state == SCAN) || (r_state == DRAIN));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_wr_pend) begin
          w_state_nxt = HOST_WR;
        end else if (r_rd_pend) begin
          w_state_nxt = HOST_RD;
        end else if (lu_req) begin
          w_state_nxt = SCAN;
        end
      end
      HOST_WR: if (tbl_wr_ack) w_state_nxt = IDLE;
      HOST_RD: if (tbl_rd_ack) w_state_nxt = IDLE;
      SCAN:    if (r_scan_addr == '1) w_state_nxt = DRAIN;
      DRAIN:   if (tbl_rd_ack && (r_ack_cnt == '1)) w_state_nxt = RESULT;
      RESULT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Table port drive
  always_comb begin
    tbl_rd_req  = 1'b0;
    tbl_rd_addr = '0;
    tbl_wr_req  = 1'b0;
    tbl_wr_addr = '0;
    tbl_wr_data = '0;
    unique case (r_state)
      SCAN: begin
        tbl_rd_req  = 1'b1;
        tbl_rd_addr = r_scan_addr;
      end
      HOST_RD: begin
        tbl_rd_req  = !r_issued;
        tbl_rd_addr = r_rd_addr;
      end
      HOST_WR: begin
        tbl_wr_req  = !r_issued;
        tbl_wr_addr = r_wr_addr;
        tbl_wr_data = r_wr_data;
      end
      default: ;
    endcase
  end

  // State, scan bookkeeping and host-access handshake
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      r_state     <= IDLE;
      r_issued    <= 1'b0;
      r_scan_addr <= '0;
      r_ack_cnt   <= '0;
      r_lu_ip     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      // Host table request is a single-cycle pulse on entry to HOST_WR/HOST_RD.
      r_issued <= ((r_state == HOST_WR) || (r_state == HOST_RD)) && (w_state_nxt == r_state);
      if (w_accept) begin
        r_lu_ip     <= lu_ip;
        r_scan_addr <= '0;
        r_ack_cnt   <= '0;
      end else begin
        if (r_state == SCAN) r_scan_addr <= r_scan_addr + 1'b1;
        if (w_scan_ack) r_ack_cnt <= r_ack_cnt + 1'b1;
      end
    end
  end

  // Host request latches; a fresh request overrides the clear on completion.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_pend <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      if (host_wr_req) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= host_wr_addr;
        r_wr_data <= host_wr_data;
      end else if ((r_state == HOST_WR) && tbl_wr_ack) begin
        r_wr_pend <= 1'b0;
      end
      if (host_rd_req) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= host_rd_addr;
      end else if ((r_state == HOST_RD) && tbl_rd_ack) begin
        r_rd_pend <= 1'b0;
      end
    end
  end

  // Host acks and read data
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      r_host_wr_ack  <= 1'b0;
      r_host_rd_ack  <= 1'b0;
      r_host_rd_data <= '0;
    end else begin
      r_host_wr_ack <= (r_state == HOST_WR) && tbl_wr_ack;
      r_host_rd_ack <= (r_state == HOST_RD) && tbl_rd_ack;
      if ((r_state == HOST_RD) && tbl_rd_ack) r_host_rd_data <= tbl_rd_data;
    end
  end

  lpm_match_cmp #(
    .ENTRY_W_P (LP_ENTRY_W),
    .IDX_W     (TBL_ADDR_BITS)
  ) u_match_cmp (
    .i_clk      (AXI_ACLK),
    .i_rst      (AXI_RESET),
    .i_clr      (w_accept),
    .i_en       (w_scan_ack),
    .i_entry    (tbl_rd_data),
    .i_idx      (r_ack_cnt),
    .i_ip       (r_lu_ip),
    .o_hit      (w_best_hit),
    .o_next_hop (w_best_hop),
    .o_oif      (w_best_oif),
    .o_idx      (w_best_idx)
  );

  // Lookup result; best-match registers are zero on a miss.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      r_lu_valid    <= 1'b0;
      r_lu_hit      <= 1'b0;
      r_lu_next_hop <= '0;
      r_lu_oif      <= '0;
      r_lu_index    <= '0;
    end else begin
      r_lu_valid <= (r_state == RESULT);
      if (r_state == RESULT) begin
        r_lu_hit      <= w_best_hit;
        r_lu_next_hop <= w_best_hop;
        r_lu_oif      <= w_best_oif;
        r_lu_index    <= w_best_idx;
      end
    end
  end

  // Statistics; clear takes precedence over a same-cycle increment.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (counter_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == RESULT) begin
      if (w_best_hit) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end else begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  assign lu_valid       = r_lu_valid;
  assign lu_hit         = r_lu_hit;
  assign lu_next_hop    = r_lu_next_hop;
  assign lu_oif         = r_lu_oif;
  assign lu_index       = r_lu_index;
  assign host_rd_data   = r_host_rd_data;
  assign host_rd_ack    = r_host_rd_ack;
  assign host_wr_ack    = r_host_wr_ack;
  assign lpm_hit_count  = r_hit_cnt;
  assign lpm_miss_count = r_miss_cnt;

endmodule

// File: tb/tb_lpm_table_scheduler.sv
`timescale 1ns/1ps
module tb_lpm_table_scheduler;

  logic         AXI_ACLK = 1'b0;
  logic         AXI_RESET;
  logic         lu_req;
  logic [31:0]  lu_ip;
  logic         lu_ready, lu_valid, lu_hit;
  logic [31:0]  lu_next_hop;
  logic [7:0]   lu_oif;
  logic [4:0]   lu_index;
  logic         host_rd_req, host_wr_req;
  logic [4:0]   host_rd_addr, host_wr_addr;
  logic [127:0] host_wr_data, host_rd_data;
  logic         host_rd_ack, host_wr_ack;
  logic         tbl_rd_req, tbl_wr_req;
  logic [4:0]   tbl_rd_addr, tbl_wr_addr;
  logic [127:0] tbl_rd_data, tbl_wr_data;
  logic         tbl_rd_ack, tbl_wr_ack;
  logic         counter_clr;
  logic [31:0]  lpm_hit_count, lpm_miss_count;

  always #5 AXI_ACLK = ~AXI_ACLK;

  lpm_table_scheduler #(
    .C_S_AXI_DATA_WIDTH (32),
    .TBL_ADDR_BITS      (5)
  ) dut (
    .AXI_ACLK       (AXI_ACLK),
    .AXI_RESET      (AXI_RESET),
    .lu_req         (lu_req),
    .lu_ip          (lu_ip),
    .lu_ready       (lu_ready),
    .lu_valid       (lu_valid),
    .lu_hit         (lu_hit),
    .lu_next_hop    (lu_next_hop),
    .lu_oif         (lu_oif),
    .lu_index       (lu_index),
    .host_rd_req    (host_rd_req),
    .host_wr_req    (host_wr_req),
    .host_rd_addr   (host_rd_addr),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .host_rd_data   (host_rd_data),
    .host_rd_ack    (host_rd_ack),
    .host_wr_ack    (host_wr_ack),
    .tbl_rd_req     (tbl_rd_req),
    .tbl_rd_addr    (tbl_rd_addr),
    .tbl_rd_data    (tbl_rd_data),
    .tbl_rd_ack     (tbl_rd_ack),
    .tbl_wr_req     (tbl_wr_req),
    .tbl_wr_addr    (tbl_wr_addr),
    .tbl_wr_data    (tbl_wr_data),
    .tbl_wr_ack     (tbl_wr_ack),
    .counter_clr    (counter_clr),
    .lpm_hit_count  (lpm_hit_count),
    .lpm_miss_count (lpm_miss_count)
  );

  // External table: 1-cycle latency, not affected by AXI_RESET.
  logic [127:0] mem [32];
  logic         mem_clr;
  always @(posedge AXI_ACLK) begin
    tbl_rd_ack  <= tbl_rd_req;
    tbl_rd_data <= tbl_rd_req ? mem[tbl_rd_addr] : 128'h0;
    tbl_wr_ack  <= tbl_wr_req;
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 128'h0;
    end else if (tbl_wr_req) begin
      mem[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  // Reference view of what the table should hold, kept by the bench.
  logic [127:0] ref_tbl [32];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [31:0]  exp_hit, exp_miss;

  function automatic logic [127:0] mk_entry(input logic [31:0] pfx, input logic [31:0] msk,
                                            input logic [31:0] hop, input logic [7:0] oif);
    return {pfx, msk, hop, 24'h0, oif};
  endfunction

  function automatic logic [31:0] len_mask(input int len);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (len == 0) ? 32'h0 : (ones << (32 - len));
  endfunction

  // Longest prefix = largest mask value; first (lowest) index kept on ties.
  function automatic void ref_lookup(input logic [31:0] ip, output logic hit,
                                     output logic [31:0] hop, output logic [7:0] oif,
                                     output logic [4:0] idx);
    logic [31:0] best_m;
    hit = 1'b0; hop = 32'h0; oif = 8'h0; idx = 5'h0; best_m = 32'h0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] p, m;
      p = ref_tbl[i][127:96];
      m = ref_tbl[i][95:64];
      if (m != 0 && ((ip ^ p) & m) == 32'h0 && (!hit || m > best_m)) begin
        hit = 1'b1; best_m = m; hop = ref_tbl[i][63:32]; oif = ref_tbl[i][7:0];
        idx = 5'(i);
      end
    end
  endfunction

  task automatic start_lookup(input logic [31:0] ip);
    @(negedge AXI_ACLK);
    lu_ip  = ip;
    lu_req = 1'b1;
    @(negedge AXI_ACLK);
    lu_req = 1'b0;
  endtask

  // Returns number of clock edges after the accepting edge, -1 on timeout.
  task automatic wait_result(input int max_cyc, output int lat);
    lat = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge AXI_ACLK);
      if (lu_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [127:0] d, output int lat);
    @(negedge AXI_ACLK);
    host_wr_req = 1'b1; host_wr_addr = a; host_wr_data = d;
    @(negedge AXI_ACLK);
    host_wr_req = 1'b0;
    ref_tbl[a] = d;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge AXI_ACLK);
      if (host_wr_ack === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic host_read(input logic [4:0] a, output logic [127:0] d, output int lat);
    @(negedge AXI_ACLK);
    host_rd_req = 1'b1; host_rd_addr = a;
    @(negedge AXI_ACLK);
    host_rd_req = 1'b0;
    lat = -1; d = 128'h0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge AXI_ACLK);
      if (host_rd_ack === 1'b1) begin
        lat = k; d = host_rd_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge AXI_ACLK);
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready got %b want 1", lu_ready); end
    n_checks++; if (lu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lu_valid got %b want 0", lu_valid); end
    n_checks++; if (tbl_rd_req !== 1'b0 || tbl_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_tbl_req got rd=%b wr=%b want 0/0", tbl_rd_req, tbl_wr_req); end
    n_checks++; if (lpm_hit_count !== 32'h0 || lpm_miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", lpm_hit_count, lpm_miss_count); end
    n_checks++; if (host_rd_ack !== 1'b0 || host_wr_ack !== 1'b0 || host_rd_data !== 128'h0) begin n_fail++; $display("FAIL reset_host_outputs got ack=%b/%b data=%h want zeros", host_rd_ack, host_wr_ack, host_rd_data); end
  endtask

  task automatic test_miss_empty();
    int lat;
    n_checks++; if (lpm_miss_count !== 32'h0) begin n_fail++; $display("FAIL miss_count_before got %0d want 0", lpm_miss_count); end
    start_lookup(32'hC0A8_0001);
    wait_result(60, lat);
    exp_miss++;
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL miss_latency got %0d want 34", lat); end
    n_checks++; if (lu_hit !== 1'b0 || lu_next_hop !== 32'h0 || lu_oif !== 8'h0 || lu_index !== 5'h0) begin n_fail++; $display("FAIL miss_result got hit=%b hop=%h oif=%h idx=%0d want all 0", lu_hit, lu_next_hop, lu_oif, lu_index); end
    n_checks++; if (lpm_miss_count !== exp_miss) begin n_fail++; $display("FAIL miss_count_after got %0d want %0d", lpm_miss_count, exp_miss); end
  endtask

  task automatic test_basic_lpm();
    int lat, wl3, wl7;
    host_write(5'd3, mk_entry(32'h0A00_0000, 32'hFF00_0000, 32'hA, 8'h01), wl3);
    host_write(5'd7, mk_entry(32'h0A01_0000, 32'hFFFF_0000, 32'hB, 8'h04), wl7);
    n_checks++; if (wl3 < 0 || wl7 < 0) begin n_fail++; $display("FAIL basic_host_wr_ack got lat %0d/%0d want acked", wl3, wl7); end
    start_lookup(32'h0A01_0203);
    wait_result(60, lat);
    exp_hit++;
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL basic_latency got %0d want 34", lat); end
    n_checks++; if (lu_hit !== 1'b1 || lu_next_hop !== 32'hB || lu_oif !== 8'h04 || lu_index !== 5'd7) begin n_fail++; $display("FAIL basic_16 got hit=%b hop=%h oif=%h idx=%0d want 1/b/04/7", lu_hit, lu_next_hop, lu_oif, lu_index); end
    n_checks++; if (lpm_hit_count !== exp_hit) begin n_fail++; $display("FAIL basic_hit_count got %0d want %0d", lpm_hit_count, exp_hit); end
    start_lookup(32'h0AC8_0001);
    wait_result(60, lat);
    exp_hit++;
    n_checks++; if (lu_hit !== 1'b1 || lu_next_hop !== 32'hA || lu_oif !== 8'h01 || lu_index !== 5'd3) begin n_fail++; $display("FAIL basic_8 got hit=%b hop=%h oif=%h idx=%0d want 1/a/01/3", lu_hit, lu_next_hop, lu_oif, lu_index); end
  endtask

  task automatic test_tie();
    int lat, w1, w2;
    host_write(5'd9, mk_entry(32'hAC10_0500, 32'hFFFF_FF00, 32'h99, 8'h09), w1);
    host_write(5'd2, mk_entry(32'hAC10_0500, 32'hFFFF_FF00, 32'h22, 8'h02), w2);
    start_lookup(32'hAC10_054D);
    wait_result(60, lat);
    exp_hit++;
    n_checks++; if (lu_hit !== 1'b1 || lu_index !== 5'd2 || lu_next_hop !== 32'h22) begin n_fail++; $display("FAIL tie_lower_index got hit=%b idx=%0d hop=%h want 1/2/22", lu_hit, lu_index, lu_next_hop); end
  endtask

  task automatic test_host_wr_during_scan();
    logic         e_hit, v_hit;
    logic [31:0]  e_hop;
    logic [7:0]   e_oif;
    logic [4:0]   e_idx, v_idx;
    logic [127:0] d, rd;
    int           lat, first_wr, ack_k, rlat;
    d = mk_entry($urandom, len_mask($urandom_range(32, 1)), $urandom, 8'($urandom));
    ref_lookup(32'h0A01_0203, e_hit, e_hop, e_oif, e_idx);
    start_lookup(32'h0A01_0203);
    lat = -1; first_wr = -1; ack_k = -1; v_hit = 1'b0; v_idx = 5'h0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge AXI_ACLK);
      if (k == 10) begin host_wr_req = 1'b1; host_wr_addr = 5'd5; host_wr_data = d; end
      if (k == 11) host_wr_req = 1'b0;
      if (tbl_wr_req === 1'b1 && first_wr < 0) first_wr = k;
      if (lu_valid === 1'b1 && lat < 0) begin lat = k; v_hit = lu_hit; v_idx = lu_index; end
      if (host_wr_ack === 1'b1) begin ack_k = k; break; end
    end
    ref_tbl[5] = d;
    if (e_hit) exp_hit++; else exp_miss++;
    n_checks++; if (lat !== 34 || v_hit !== e_hit || v_idx !== e_idx) begin n_fail++; $display("FAIL scanwr_result got lat=%0d hit=%b idx=%0d want 34/%b/%0d", lat, v_hit, v_idx, e_hit, e_idx); end
    n_checks++; if (first_wr <= lat || lat < 0) begin n_fail++; $display("FAIL scanwr_no_mid_scan_write got first tbl_wr_req at %0d lu_valid at %0d want write after valid", first_wr, lat); end
    n_checks++; if (ack_k <= first_wr) begin n_fail++; $display("FAIL scanwr_ack got ack at %0d first write at %0d want ack after write", ack_k, first_wr); end
    host_read(5'd5, rd, rlat);
    n_checks++; if (rlat < 0 || rd !== d) begin n_fail++; $display("FAIL scanwr_readback got %h (lat %0d) want %h", rd, rlat, d); end
  endtask

  task automatic test_wr_rd_same_cycle();
    logic [127:0] d, rd;
    int           wr_k, rd_k;
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge AXI_ACLK);
    host_wr_req = 1'b1; host_wr_addr = 5'd4; host_wr_data = d;
    host_rd_req = 1'b1; host_rd_addr = 5'd4;
    @(negedge AXI_ACLK);
    host_wr_req = 1'b0; host_rd_req = 1'b0;
    ref_tbl[4] = d;
    wr_k = -1; rd_k = -1; rd = 128'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge AXI_ACLK);
      if (host_wr_ack === 1'b1 && wr_k < 0) wr_k = k;
      if (host_rd_ack === 1'b1 && rd_k < 0) begin rd_k = k; rd = host_rd_data; end
      if (wr_k >= 0 && rd_k >= 0) break;
    end
    n_checks++; if (wr_k < 0 || rd_k <= wr_k) begin n_fail++; $display("FAIL wrrd_order got wr ack %0d rd ack %0d want write first", wr_k, rd_k); end
    n_checks++; if (rd !== d) begin n_fail++; $display("FAIL wrrd_data got %h want %h", rd, d); end
  endtask

  task automatic test_random_lookups();
    logic        e_hit;
    logic [31:0] e_hop, ip, p, m;
    logic [7:0]  e_oif;
    logic [4:0]  e_idx, a;
    int          lat, wl;
    for (int n = 0; n < 10; n++) begin
      a = 5'($urandom_range(31, 0));
      m = len_mask($urandom_range(32, 0));
      host_write(a, mk_entry($urandom, m, $urandom, 8'($urandom)), wl);
    end
    for (int n = 0; n < 10; n++) begin
      a = 5'($urandom_range(31, 0));
      p = ref_tbl[a][127:96];
      m = ref_tbl[a][95:64];
      ip = (n % 3 == 2) ? $urandom : ((p & m) | ($urandom & ~m));
      ref_lookup(ip, e_hit, e_hop, e_oif, e_idx);
      if (e_hit) exp_hit++; else exp_miss++;
      start_lookup(ip);
      wait_result(60, lat);
      n_checks++; if (lat !== 34 || lu_hit !== e_hit || lu_next_hop !== e_hop || lu_oif !== e_oif || lu_index !== e_idx) begin
        n_fail++;
        $display("FAIL rand_lookup ip=%h got lat=%0d hit=%b hop=%h oif=%h idx=%0d want 34/%b/%h/%h/%0d", ip, lat, lu_hit, lu_next_hop, lu_oif, lu_index, e_hit, e_hop, e_oif, e_idx);
      end
      n_checks++; if (lpm_hit_count !== exp_hit || lpm_miss_count !== exp_miss) begin n_fail++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d", lpm_hit_count, lpm_miss_count, exp_hit, exp_miss); end
    end
  endtask

  task automatic test_counter_clr();
    int lat;
    // Clear held across the RESULT cycle must beat the increment.
    @(negedge AXI_ACLK);
    counter_clr = 1'b1;
    start_lookup(32'h0A01_0203);
    wait_result(60, lat);
    n_checks++; if (lat !== 34 || lpm_hit_count !== 32'h0 || lpm_miss_count !== 32'h0) begin n_fail++; $display("FAIL clr_wins got lat=%0d counts %0d/%0d want 34 0/0", lat, lpm_hit_count, lpm_miss_count); end
    counter_clr = 1'b0;
    exp_hit = 0; exp_miss = 0;
    start_lookup(32'hC0A8_0001);
    wait_result(60, lat);
    if (lu_hit === 1'b1) exp_hit++; else exp_miss++;
    n_checks++; if (lpm_hit_count + lpm_miss_count !== 32'd1) begin n_fail++; $display("FAIL clr_resume got counts %0d/%0d want total 1", lpm_hit_count, lpm_miss_count); end
  endtask

  task automatic test_reset_mid_scan();
    logic        seen_valid, e_hit;
    logic [31:0] e_hop;
    logic [7:0]  e_oif;
    logic [4:0]  e_idx;
    int          lat;
    start_lookup(32'h0A01_0203);
    for (int k = 1; k <= 15; k++) @(negedge AXI_ACLK);
    AXI_RESET = 1'b1;
    @(negedge AXI_ACLK);
    AXI_RESET = 1'b0;
    exp_hit = 0; exp_miss = 0;
    #1;
    n_checks++; if (lu_ready !== 1'b1 || tbl_rd_req !== 1'b0) begin n_fail++; $display("FAIL rstscan_ready got ready=%b rd_req=%b want 1/0", lu_ready, tbl_rd_req); end
    seen_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge AXI_ACLK);
      if (lu_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL rstscan_no_valid got lu_valid seen=%b want 0", seen_valid); end
    n_checks++; if (lpm_hit_count !== 32'h0 || lpm_miss_count !== 32'h0) begin n_fail++; $display("FAIL rstscan_counters got %0d/%0d want 0/0", lpm_hit_count, lpm_miss_count); end
    ref_lookup(32'h0A01_0203, e_hit, e_hop, e_oif, e_idx);
    start_lookup(32'h0A01_0203);
    wait_result(60, lat);
    n_checks++; if (lat !== 34 || lu_hit !== e_hit || lu_index !== e_idx || lu_next_hop !== e_hop) begin n_fail++; $display("FAIL rstscan_after got lat=%0d hit=%b idx=%0d hop=%h want 34/%b/%0d/%h", lat, lu_hit, lu_index, lu_next_hop, e_hit, e_idx, e_hop); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    AXI_RESET = 1'b1; lu_req = 1'b0; lu_ip = 32'h0;
    host_rd_req = 1'b0; host_wr_req = 1'b0; host_rd_addr = 5'h0; host_wr_addr = 5'h0;
    host_wr_data = 128'h0; counter_clr = 1'b0; mem_clr = 1'b1;
    exp_hit = 0; exp_miss = 0;
    for (int i = 0; i < 32; i++) ref_tbl[i] = 128'h0;
    repeat (3) @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    mem_clr   = 1'b0;
    AXI_RESET = 1'b0;

    test_reset();
    test_miss_empty();
    test_basic_lpm();
    test_tie();
    test_host_wr_during_scan();
    test_wr_rd_same_cycle();
    test_random_lookups();
    test_counter_clr();
    test_reset_mid_scan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lpm_table_scheduler.md
LPM_TABLE_SCHEDULER -- requirements
Module: lpm_table_scheduler

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: host word width; a table entry is 4 words (128 b).
REQ-002 Parameter TBL_ADDR_BITS, default 5: table depth is 2^TBL_ADDR_BITS (32 entries).
REQ-003 Ports: AXI_ACLK in 1, sole clock; AXI_RESET in 1, asynchronous active-high reset.
REQ-004 Lookup ports: lu_req in 1; lu_ip in 32; lu_ready out 1; lu_valid out 1; lu_hit out 1; lu_next_hop out 32; lu_oif out 8; lu_index out 5.
REQ-005 Host ports: host_rd_req in 1; host_wr_req in 1; host_rd_addr in 5; host_wr_addr in 5; host_wr_data in 128; host_rd_data out 128; host_rd_ack out 1; host_wr_ack out 1.
REQ-006 Table ports: tbl_rd_req out 1; tbl_rd_addr out 5; tbl_rd_data in 128; tbl_rd_ack in 1; tbl_wr_req out 1; tbl_wr_addr out 5; tbl_wr_data out 128; tbl_wr_ack in 1.
REQ-007 Statistics ports: counter_clr in 1; lpm_hit_count out 32; lpm_miss_count out 32.

Function
REQ-008 Entry format: [127:96] prefix, [95:64] mask, [63:32] next hop, [7:0] oif; mask 0 = invalid entry, never matches.
REQ-009 FSM states IDLE, HOST_WR, HOST_RD, SCAN, DRAIN, RESULT; reset state IDLE.
REQ-010 host_rd_req/host_wr_req pulses latched into pending flags with address/data; a second request of the same type while pending overwrites the latched request.
REQ-011 IDLE priority: pending write > pending read > lookup.
REQ-012 lu_ready = 1 only in IDLE with no host request pending; lookup accepted on lu_req & lu_ready; lu_ip registered at acceptance.
REQ-013 HOST_WR: tbl_wr_req pulsed one cycle; on tbl_wr_ack, host_wr_ack pulses one cycle, pending cleared, return to IDLE.
REQ-014 HOST_RD: tbl_rd_req pulsed one cycle; on tbl_rd_ack, host_rd_data captured, host_rd_ack pulses one cycle, return to IDLE.
REQ-015 SCAN: tbl_rd_req held high 32 consecutive cycles, tbl_rd_addr 0..31 ascending; then DRAIN until 32 tbl_rd_ack received.
REQ-016 Each acked entry matches when mask != 0 and (lu_ip & mask) == (prefix & mask); best kept in registers.
REQ-017 Longer prefix = numerically larger mask; on equal masks the lower index wins.
REQ-018 RESULT: lu_valid pulses one cycle with lu_hit, lu_next_hop, lu_oif, lu_index; on miss lu_hit=0 and other result fields 0.
REQ-019 With 1-cycle table latency, lu_valid asserts exactly 34 cycles after the accepting edge.
REQ-020 Host requests arriving during SCAN/DRAIN are latched and served only after RESULT; no table write ever occurs mid-scan.
REQ-021 lpm_hit_count / lpm_miss_count increment in RESULT; saturate at 2^32-1.
REQ-022 counter_clr zeroes both counters; on the same cycle as an increment, clear wins.
REQ-023 Simultaneous host_rd_req and host_wr_req: both latched; write served first.

Reset
REQ-024 AXI_RESET asynchronously forces IDLE, clears pending flags and best-match registers, and zeroes all outputs (lu_ready reads 1 once AXI_RESET deasserts).
REQ-025 Reset mid-scan abandons the lookup: no lu_valid, no counter update; acks arriving after reset are ignored.

Structure
REQ-026 Shared package holds entry field offsets, the state enumeration, TBL_ADDR_BITS, and the oif width.
REQ-027 One sub-module, lpm_match_cmp, performs the registered match and longer-prefix compare of one entry against the current best.

Verification
REQ-028 Entries 3 (10.0.0.0/8, hop 0xA, oif 0x01) and 7 (10.1.0.0/16, hop 0xB, oif 0x04); lookup 10.1.2.3 -> lu_hit=1, lu_next_hop=0xB, lu_oif=0x04, lu_index=7, lu_valid 34 cycles after accept.
REQ-029 Empty table; lookup 192.168.0.1 -> lu_hit=0, lu_next_hop=0, lpm_miss_count 0->1.
REQ-030 Identical /24 entries at indices 2 and 9; matching lookup -> lu_index=2.
REQ-031 host_wr_req to addr 5 issued 10 cycles into a scan -> tbl_wr_req not asserted until after lu_valid; host_wr_ack follows; readback of addr 5 returns the written data.
REQ-032 host_wr_req and host_rd_req in the same cycle to addr 4 -> write acked before read; host_rd_data equals the written value.
REQ-033 AXI_RESET pulsed at scan cycle 15 -> no lu_valid, counters unchanged, lu_ready=1 once AXI_RESET deasserts.
